spi_arbiter: RTL

Shares the single SPI_mnrch master between two requesters: requester 0 (A2D conversion sequencer) and requester 1 (on-demand/diagnostic SPI accesses). It arbitrates round-robin, multiplexes the command to the master, and routes done/resp back to the owner. A lock mechanism keeps the bus for back-to-back transactions; the A2D needs this for its channel-select transaction followed by its read transaction. A watchdog releases a lock that is held but not used.

---
 rtl/spi_arbiter_if.sv | 13 +
 rtl/spi_arbiter.sv | 61 ++++++
 2 files changed

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: requester req/cmd/lock/gnt/done/resp, shared SPI_mnrch snd/cmd/done/resp, busy/owner/tmo_err status
interface spi_arbiter_if;
  logic req0, lock0, req1, lock1, gnt0, gnt1, done0, done1, spi_snd, spi_done, busy, owner, tmo_err;
  logic [15:0] cmd0, cmd1, resp, spi_cmd, spi_resp;
  modport slave(
    input req0, cmd0, lock0, req1, cmd1, lock1, spi_done, spi_resp,
    output gnt0, gnt1, done0, done1, resp, spi_snd, spi_cmd, busy, owner, tmo_err
  );
  modport master(
    output req0, cmd0, lock0, req1, cmd1, lock1, spi_done, spi_resp,
    input gnt0, gnt1, done0, done1, resp, spi_snd, spi_cmd, busy, owner, tmo_err
  );
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of SPI_mnrch between two requesters with bus lock and lock watchdog; ports clk, rst_n, bus (spi_arbiter_if.slave)
module spi_arbiter #(
  parameter int LOCK_TMO = 600
) (
  input logic clk,
  input logic rst_n,
  spi_arbiter_if.slave bus
);
  localparam int TW = $clog2(LOCK_TMO + 1);
  typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;
  state_t state, state_nx;
  logic rr_ptr, owner, lock_q, snd, gnt0, gnt1, sel, own_req, launch, fin, tmo;
  logic [15:0] cmd_q, resp_q;
  logic [TW-1:0] tmr;
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  always_comb begin
    own_req = owner ? bus.req1 : bus.req0;
    sel = (state == HOLD) ? owner : ((bus.req0 && bus.req1) ? rr_ptr : bus.req1);
    launch = (state == IDLE) ? (bus.req0 || bus.req1) : (state == HOLD && own_req);
    fin = state == XFER && bus.spi_done;
    tmo = state == HOLD && !own_req && tmr == TW'(LOCK_TMO);
    state_nx = launch ? XFER : tmo ? IDLE : fin ? (lock_q ? HOLD : IDLE) : state;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      rr_ptr <= 1'b0;
      owner <= 1'b0;
      lock_q <= 1'b0;
      snd <= 1'b0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      cmd_q <= '0;
      resp_q <= '0;
      tmr <= '0;
    end else begin
      snd <= launch;
      gnt0 <= launch && !sel;
      gnt1 <= launch && sel;
      tmr <= (state == HOLD && !own_req && !tmo) ? tmr + 1'b1 : '0;
      if (launch) begin
        owner <= sel;
        cmd_q <= sel ? bus.cmd1 : bus.cmd0;
        lock_q <= sel ? bus.lock1 : bus.lock0;
      end
      if (fin) resp_q <= bus.spi_resp;
      if ((fin && !lock_q) || tmo) rr_ptr <= ~owner;
      if (tmo) lock_q <= 1'b0;
    end
  always_comb begin
    bus.spi_snd = snd;
    bus.spi_cmd = cmd_q;
    bus.gnt0 = gnt0;
    bus.gnt1 = gnt1;
    bus.done0 = fin && !owner;
    bus.done1 = fin && owner;
    bus.resp = fin ? bus.spi_resp : resp_q;
    bus.busy = state != IDLE;
    bus.owner = owner;
    bus.tmo_err = tmo;
  end
endmodule
